// File: rtl/f1_reaction_timer.sv
// Random-hold reaction timer: waits an LFSR-chosen number of ticks, then times the press.
// Optional false-start detection is enabled by defining F1_FALSE_START_EN.
module f1_reaction_timer #(
    parameter int RT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            start,
    input  logic            react,
    output logic            time_out,
    output logic            lights_off,
    output logic            busy,
    output logic [RT_W-1:0] react_time,
    output logic            react_valid,
    output logic            false_start
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        REACT = 2'd2
    } state_t;

    state_t          state;
    logic [6:0]      lfsr;
    logic            start_d;
    logic [6:0]      count;
    logic [RT_W-1:0] rt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            lfsr        <= 7'h01;
            start_d     <= 1'b0;
            count       <= '0;
            rt          <= '0;
            time_out    <= 1'b0;
            lights_off  <= 1'b0;
            busy        <= 1'b0;
            react_time  <= '0;
            react_valid <= 1'b0;
            false_start <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; pulse outputs default low each cycle and are
            // raised only by the branch that owns them, so no state is read mid-update.
            lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[2]};
            start_d     <= start;
            time_out    <= 1'b0;
            react_valid <= 1'b0;
            false_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !start_d) begin
                        count <= lfsr;
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end

                COUNT: begin
`ifdef F1_FALSE_START_EN
                    // A premature press beats a terminal tick arriving in the same cycle.
                    if (react) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        false_start <= 1'b1;
                    end else
`endif
                    if (en) begin
                        if (count == 7'd1) begin
                            state      <= REACT;
                            time_out   <= 1'b1;
                            lights_off <= 1'b1;
                            rt         <= '0;
                        end else begin
                            count <= count - 7'd1;
                        end
                    end
                end

                REACT: begin
                    // Leaving at all-ones is the saturation: rt never wraps.
                    if (react || (rt == {RT_W{1'b1}})) begin
                        react_time  <= rt;
                        react_valid <= 1'b1;
                        state       <= IDLE;
                        lights_off  <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        rt <= rt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    lights_off <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer: a default-width instance and an RT_W=4 instance
// for saturation. Expected values are hand-derived from the LFSR sequence 01,02,04,...
module tb_f1_reaction_timer;

    logic       clk;
    logic       rst, en, start, react;
    logic       time_out, lights_off, busy, react_valid, false_start;
    logic [15:0] react_time;

    logic       rst4, en4, start4, react4;
    logic       time_out4, lights_off4, busy4, react_valid4, false_start4;
    logic [3:0] react_time4;

    int vectors;
    int miscompares;

    f1_reaction_timer #(.RT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .react(react),
        .time_out(time_out), .lights_off(lights_off), .busy(busy),
        .react_time(react_time), .react_valid(react_valid), .false_start(false_start)
    );

    f1_reaction_timer #(.RT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .start(start4), .react(react4),
        .time_out(time_out4), .lights_off(lights_off4), .busy(busy4),
        .react_time(react_time4), .react_valid(react_valid4), .false_start(false_start4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_time_out(input int budget, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            if (time_out) seen = 1'b1;
        end
    endtask

    initial begin
        logic seen;
        int   first_to, strobes, strobes_at_to, to_pulses;

        vectors = 0;
        miscompares = 0;
        rst = 1'b0; start = 1'b0; en = 1'b0; react = 1'b0;
        rst4 = 1'b0; start4 = 1'b0; en4 = 1'b0; react4 = 1'b0;

        // Reset state
        step(); step();
        chk("rst_time_out",    32'(time_out),    32'd0);
        chk("rst_lights_off",  32'(lights_off),  32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_react_time",  32'(react_time),  32'd0);
        chk("rst_react_valid", 32'(react_valid), 32'd0);
        chk("rst_false_start", 32'(false_start), 32'd0);
        chk("rst_lfsr",        32'(dut.lfsr),    32'h01);

        // Start in first cycle after release: L=1, lights out two edges later
        rst = 1'b1; start = 1'b1; en = 1'b1;
        step();
        chk("t1_busy_rise",    32'(busy),       32'd1);
        chk("t1_no_early_to",  32'(time_out),   32'd0);
        step();
        chk("t1_time_out",     32'(time_out),   32'd1);
        chk("t1_lights_on",    32'(lights_off), 32'd1);
        step();
        chk("t1_to_one_cycle", 32'(time_out),   32'd0);
        chk("t1_lights_hold",  32'(lights_off), 32'd1);
        repeat (4) step();
        react = 1'b1;
        step();
        react = 1'b0;
        chk("t1_valid",        32'(react_valid), 32'd1);
        chk("t1_react_time",   32'(react_time),  32'd5);
        chk("t1_lights_fall",  32'(lights_off),  32'd0);
        chk("t1_busy_fall",    32'(busy),        32'd0);
        step();
        chk("t1_valid_pulse",  32'(react_valid), 32'd0);
        chk("t1_time_held",    32'(react_time),  32'd5);

        // start still high: no re-trigger
        repeat (3) step();
        chk("t1_no_retrigger", 32'(busy), 32'd0);

        // Re-arm, hold in COUNT with en=0, then press early
        start = 1'b0; en = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("fs_busy_rise", 32'(busy), 32'd1);
        step();
        chk("fs_hold_busy", 32'(busy),     32'd1);
        chk("fs_hold_no_to", 32'(time_out), 32'd0);
        react = 1'b1;
        step();
        react = 1'b0;
`ifdef F1_FALSE_START_EN
        chk("fs_pulse",      32'(false_start), 32'd1);
        chk("fs_idle",       32'(busy),        32'd0);
        chk("fs_time_kept",  32'(react_time),  32'd5);
        chk("fs_lights_off", 32'(lights_off),  32'd0);
        step();
        chk("fs_one_cycle",  32'(false_start), 32'd0);
`else
        chk("fs_ignored",    32'(false_start), 32'd0);
        chk("fs_still_busy", 32'(busy),        32'd1);
        en = 1'b1;
        wait_time_out(140, seen);
        chk("fs_to_fires",   32'(seen),        32'd1);
        react = 1'b1;
        step();
        react = 1'b0;
        chk("fs_valid",      32'(react_valid), 32'd1);
        chk("fs_time_zero",  32'(react_time),  32'd0);
`endif

        // Start in 3rd cycle after release (L=4), en 1-in-4
        start = 1'b0; en = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step(); step();
        chk("t2_lfsr_cycle3", 32'(dut.lfsr), 32'h04);
        start = 1'b1;
        step();
        chk("t2_busy_rise", 32'(busy), 32'd1);
        first_to = 0; strobes = 0; strobes_at_to = 0; to_pulses = 0;
        for (int j = 1; j <= 24; j++) begin
            en = (j % 4 == 0);
            if (en) strobes++;
            step();
            if (time_out) begin
                to_pulses++;
                if (first_to == 0) begin
                    first_to = j;
                    strobes_at_to = strobes;
                end
            end
        end
        en = 1'b0;
        chk("t2_to_step",    32'(first_to),      32'd16);
        chk("t2_to_strobes", 32'(strobes_at_to), 32'd4);
        chk("t2_to_pulses",  32'(to_pulses),     32'd1);
        chk("t2_in_react",   32'(lights_off),    32'd1);

        // Reset during REACT
        rst = 1'b0;
        step();
        chk("mr_time_out",    32'(time_out),    32'd0);
        chk("mr_lights_off",  32'(lights_off),  32'd0);
        chk("mr_busy",        32'(busy),        32'd0);
        chk("mr_react_time",  32'(react_time),  32'd0);
        chk("mr_react_valid", 32'(react_valid), 32'd0);
        chk("mr_false_start", 32'(false_start), 32'd0);
        chk("mr_lfsr",        32'(dut.lfsr),    32'h01);

        // Release with start high (L=1): press coincides with the terminal tick
        rst = 1'b1; en = 1'b1;
        step();
        chk("sim_no_stale_valid", 32'(react_valid), 32'd0);
        chk("sim_busy",           32'(busy),        32'd1);
        react = 1'b1;
        step();
        react = 1'b0;
`ifdef F1_FALSE_START_EN
        chk("sim_fs_wins", 32'(false_start), 32'd1);
        chk("sim_no_to",   32'(time_out),    32'd0);
        chk("sim_idle",    32'(busy),        32'd0);
`else
        chk("sim_to",      32'(time_out),    32'd1);
        chk("sim_no_fs",   32'(false_start), 32'd0);
        step(); step();
        react = 1'b1;
        step();
        react = 1'b0;
        chk("sim_valid",   32'(react_valid), 32'd1);
        chk("sim_time",    32'(react_time),  32'd2);
`endif

        // RT_W=4 saturation with no press
        rst4 = 1'b1; start4 = 1'b1; en4 = 1'b1;
        step();
        chk("sat_busy",      32'(busy4),       32'd1);
        step();
        chk("sat_time_out",  32'(time_out4),   32'd1);
        repeat (15) step();
        chk("sat_in_react",  32'(lights_off4), 32'd1);
        chk("sat_no_valid",  32'(react_valid4), 32'd0);
        step();
        chk("sat_valid",     32'(react_valid4), 32'd1);
        chk("sat_time",      32'(react_time4),  32'd15);
        chk("sat_idle",      32'(busy4),        32'd0);
        chk("sat_lights",    32'(lights_off4),  32'd0);
        step();
        chk("sat_pulse",     32'(react_valid4), 32'd0);
        chk("sat_held",      32'(react_time4),  32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
